// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALU and mux
// encodings, the control FSM state set and the packed control-word layout.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // alu_op classes consumed by the ALU control stage
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDI_EX = 4'd11,
        S_ADDI_WB = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    // Dispatch target out of DECODE for a given opcode.
    function automatic state_t decode_target(input logic [5:0] op);
        state_t s;
        case (op)
            OP_LW, OP_SW: s = S_MEMADR;
            OP_RTYPE:     s = S_EXEC;
            OP_BEQ:       s = S_BRANCH;
            OP_J:         s = S_JUMP;
            OP_ADDI:      s = S_ADDI_EX;
            default:      s = S_ILLEGAL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath. Moore outputs decoded from
// the state register; only memory-handshake strobes also look at mem_ready.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       instr_done
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_opcode;
    ctrl_t      w_ctrl;

    // The opcode is captured on leaving DECODE so later IR changes cannot
    // steer the lw/sw split in MEMADR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_opcode <= 6'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
            end
        end
    end

    always_comb begin
        w_next = S_FETCH;
        w_ctrl = '0;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = ALUSRCB_FOUR;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.pc_source = PCSRC_ALU;
                w_ctrl.ir_write  = mem_ready;
                w_ctrl.pc_write  = mem_ready;
                w_next           = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = ALUSRCB_IMM_SL2;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_next           = decode_target(opcode);
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALUSRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_next           = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
                w_next          = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_ctrl.reg_dst    = 1'b0;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            S_MEMWR: begin
                // mem_write is held through wait states; done only on the ready cycle.
                w_ctrl.iord       = 1'b1;
                w_ctrl.mem_write  = 1'b1;
                w_ctrl.instr_done = mem_ready;
                w_next            = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALUSRCB_B;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_next           = S_RWB;
            end
            S_RWB: begin
                w_ctrl.reg_dst    = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b0;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = ALUSRCB_B;
                w_ctrl.alu_op        = ALUOP_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
                w_ctrl.instr_done    = 1'b1;
                w_next               = S_FETCH;
            end
            S_JUMP: begin
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = PCSRC_JUMP;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            S_ADDI_EX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALUSRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_next           = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_ctrl.reg_dst    = 1'b0;
                w_ctrl.mem_to_reg = 1'b0;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            S_ILLEGAL: begin
                // PC already advanced in FETCH, so the bad word is simply skipped.
                w_ctrl.illegal_op = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            default: begin
                w_ctrl = '0;
                w_next = S_FETCH;
            end
        endcase
    end

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign iord          = w_ctrl.iord;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_dst       = w_ctrl.reg_dst;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_source     = w_ctrl.pc_source;
    assign illegal_op    = w_ctrl.illegal_op;
    assign instr_done    = w_ctrl.instr_done;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a vector table of per-cycle inputs and expected
// control words, checked through a scoreboard queue, plus reset sequences.
module tb_multicycle_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, instr_done;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .instr_done(instr_done)
    );

    // Control word order: pcw pcwc iord mrd mwr irw m2r rdst rwr asa asb[2] aop[2] psrc[2] ill done
    logic [17:0] act;
    assign act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, illegal_op, instr_done};

    localparam logic [17:0] E_IDLE    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_FETCH_R = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] E_FETCH_W = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] E_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] E_MEMADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] E_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_MEMWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1;
    localparam logic [17:0] E_MEMWR_W = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_MEMWR_R = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1;
    localparam logic [17:0] E_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] E_RWB     = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_1;
    localparam logic [17:0] E_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1;
    localparam logic [17:0] E_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_1;
    localparam logic [17:0] E_ADDI_EX = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] E_ADDI_WB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_1;
    localparam logic [17:0] E_ILLEGAL = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_1;

    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [17:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [17:0] sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        prev_done = 1'b0;
    logic        prev_ill  = 1'b0;

    task automatic add(input logic [5:0] op, input logic rdy, input logic [17:0] exp);
        vec_t v;
        v.op = op; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Pops the oldest expected word and compares it with the live outputs.
    task automatic check(input string tag);
        logic [17:0] exp;
        if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: scoreboard empty, got %b", tag, act);
            return;
        end
        exp = sb_q.pop_front();
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", tag, act, exp);
        end
        n_cmp++;
        if ((prev_done && instr_done) || (prev_ill && illegal_op)) begin
            n_err++;
            $display("FAIL %s_pulse: done %b->%b illegal %b->%b, required single-cycle pulses",
                     tag, prev_done, instr_done, prev_ill, illegal_op);
        end
        prev_done = instr_done;
        prev_ill  = illegal_op;
    endtask

    task automatic step(input logic [5:0] op, input logic rdy, input logic [17:0] exp,
                        input string tag);
        @(negedge clk);
        opcode    = op;
        mem_ready = rdy;
        sb_q.push_back(exp);
        #1;
        check(tag);
        $display("cycle %s op=%b rdy=%b ctrl=%b", tag, op, rdy, act);
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = OP_BAD;
        mem_ready = 1'b1;

        // lw, single-cycle memory
        add(OP_BAD, 1, E_FETCH_R); add(OP_LW, 1, E_DECODE); add(OP_BAD, 0, E_MEMADR);
        add(OP_BAD, 1, E_MEMRD);   add(OP_BAD, 0, E_MEMWB);
        // sw with two wait states
        add(OP_BAD, 1, E_FETCH_R); add(OP_SW, 1, E_DECODE); add(OP_BAD, 1, E_MEMADR);
        add(OP_BAD, 0, E_MEMWR_W); add(OP_BAD, 0, E_MEMWR_W); add(OP_BAD, 1, E_MEMWR_R);
        // R-type then beq
        add(OP_BAD, 1, E_FETCH_R); add(OP_RTYPE, 1, E_DECODE); add(OP_BAD, 0, E_EXEC);
        add(OP_BAD, 1, E_RWB);
        add(OP_BAD, 1, E_FETCH_R); add(OP_BEQ, 1, E_DECODE);   add(OP_BAD, 0, E_BRANCH);
        // FETCH stall of three cycles, then addi
        add(OP_BAD, 0, E_FETCH_W); add(OP_BAD, 0, E_FETCH_W); add(OP_BAD, 0, E_FETCH_W);
        add(OP_BAD, 1, E_FETCH_R); add(OP_ADDI, 1, E_DECODE); add(OP_BAD, 1, E_ADDI_EX);
        add(OP_BAD, 0, E_ADDI_WB);
        // illegal opcode, then jump
        add(OP_BAD, 1, E_FETCH_R); add(OP_BAD, 1, E_DECODE);  add(OP_BAD, 1, E_ILLEGAL);
        add(OP_BAD, 1, E_FETCH_R); add(OP_J, 1, E_DECODE);    add(OP_BAD, 1, E_JUMP);
        // lw whose IR changes to sw after DECODE, with one MEMRD wait state
        add(OP_BAD, 1, E_FETCH_R); add(OP_LW, 1, E_DECODE);   add(OP_SW, 1, E_MEMADR);
        add(OP_SW, 0, E_MEMRD);    add(OP_SW, 1, E_MEMRD);    add(OP_SW, 1, E_MEMWB);
        // lead into EXEC for the mid-instruction reset
        add(OP_BAD, 1, E_FETCH_R); add(OP_RTYPE, 1, E_DECODE); add(OP_BAD, 1, E_EXEC);

        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(E_IDLE);
        check("in_reset");

        @(negedge clk);
        reset_n = 1'b1;
        sb_q.push_back(E_IDLE);
        #1;
        check("release_idle");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].op, vecs[i].rdy, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Asynchronous reset while in EXEC: outputs must drop without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        sb_q.push_back(E_IDLE);
        check("async_reset");
        @(posedge clk);
        #1;
        sb_q.push_back(E_IDLE);
        check("reset_held");
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.push_back(E_IDLE);
        #1;
        check("rerelease_idle");
        step(OP_BAD, 1, E_FETCH_R, "first_fetch");
        step(OP_J, 1, E_DECODE, "post_rst_decode");
        step(OP_BAD, 1, E_JUMP, "post_rst_jump");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
